// File: rtl/mouse_packet_receiver.sv
// PS/2 mouse receiver: deserializes 11-bit PS/2 frames from the raw clock/data
// lines and assembles 3-byte movement packets for the position accumulator.
// Latency: tx rises FILTER_LEN+3 qzt_clk cycles after the raw ps2_clk fall
// that samples the stop bit of byte 2. No backpressure: the mouse cannot be stalled.
//
// Ports:
//   qzt_clk, rst_n        system clock, synchronous active-low reset
//   ps2_clk, ps2_data     raw asynchronous PS/2 lines
//   status/deltaX/deltaY  bytes 0/1/2 of the last good packet (held)
//   tx                    one-cycle pulse per new packet
//   err                   one-cycle pulse on parity/stop error or timeout
module mouse_packet_receiver #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       qzt_clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] status,
  output logic [7:0] deltaX,
  output logic [7:0] deltaY,
  output logic       tx,
  output logic       err
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

  state_t          state, state_nxt;
  logic            clk_s1, clk_s2, data_s1, data_s2;
  logic            filt, filt_d;
  logic [FW-1:0]   filt_cnt;
  logic [TW-1:0]   tcnt;
  logic [2:0]      bit_cnt;
  logic [7:0]      shift;
  logic            par_bit;
  logic [1:0]      byte_idx;
  logic [7:0]      shadow0, shadow1;
  logic            sample, active, timeout, frame_good, frame_bad;

  // One-cycle sample strobe on the falling edge of the filtered clock.
  assign sample = filt_d & ~filt;
  // The timeout only guards partial frames or partial packets.
  assign active = (state != S_IDLE) || (byte_idx != 2'd0);

  always_comb begin
    state_nxt  = state;
    frame_good = 1'b0;
    frame_bad  = 1'b0;
    // A sample in the expiry cycle takes precedence over the timeout.
    timeout    = active && !sample && (tcnt == TW'(TIMEOUT_CYCLES - 1));
    if (sample) begin
      case (state)
        S_IDLE:   if (!data_s2) state_nxt = S_DATA;   // data=1 here is line noise
        S_DATA:   if (bit_cnt == 3'd7) state_nxt = S_PARITY;
        S_PARITY: state_nxt = S_STOP;
        S_STOP: begin
          state_nxt = S_IDLE;
          // Odd parity: data bits plus parity bit must XOR to 1.
          if (data_s2 && (^shift ^ par_bit)) frame_good = 1'b1;
          else                               frame_bad  = 1'b1;
        end
        default:  state_nxt = S_IDLE;
      endcase
    end else if (timeout) begin
      state_nxt = S_IDLE;
    end
  end

  always_ff @(posedge qzt_clk) begin
    if (!rst_n) begin
      clk_s1   <= 1'b1;
      clk_s2   <= 1'b1;
      data_s1  <= 1'b1;
      data_s2  <= 1'b1;
      filt     <= 1'b1;
      filt_d   <= 1'b1;
      filt_cnt <= '0;
      tcnt     <= '0;
      state    <= S_IDLE;
      bit_cnt  <= '0;
      shift    <= '0;
      par_bit  <= 1'b0;
      byte_idx <= '0;
      shadow0  <= '0;
      shadow1  <= '0;
      status   <= '0;
      deltaX   <= '0;
      deltaY   <= '0;
      tx       <= 1'b0;
      err      <= 1'b0;
    end else begin
      clk_s1  <= ps2_clk;
      clk_s2  <= clk_s1;
      data_s1 <= ps2_data;
      data_s2 <= data_s1;

      // Filtered clock flips only after FILTER_LEN consecutive disagreeing cycles.
      if (clk_s2 == filt) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
        filt     <= clk_s2;
        filt_cnt <= '0;
      end else begin
        filt_cnt <= filt_cnt + 1'b1;
      end
      filt_d <= filt;

      state <= state_nxt;
      tx    <= 1'b0;
      err   <= frame_bad || timeout;

      if (sample || timeout || !active) tcnt <= '0;
      else                              tcnt <= tcnt + 1'b1;

      if (sample) begin
        case (state)
          S_IDLE:   bit_cnt <= '0;
          S_DATA: begin
            shift   <= {data_s2, shift[7:1]};   // LSB arrives first
            bit_cnt <= bit_cnt + 1'b1;
          end
          S_PARITY: par_bit <= data_s2;
          default:  ;
        endcase
      end

      if (frame_bad || timeout) begin
        byte_idx <= '0;
      end else if (frame_good) begin
        case (byte_idx)
          2'd0: begin
            // Byte 0 always has bit3 set; anything else means we are misaligned.
            if (shift[3]) begin
              shadow0  <= shift;
              byte_idx <= 2'd1;
            end
          end
          2'd1: begin
            shadow1  <= shift;
            byte_idx <= 2'd2;
          end
          default: begin
            status   <= shadow0;
            deltaX   <= shadow1;
            deltaY   <= shift;
            tx       <= 1'b1;
            byte_idx <= 2'd0;
          end
        endcase
      end
    end
  end

endmodule
